mesh_inject_sequencer: RTL
==========================

// Module: mesh_inject_sequencer
// PURPOSE
// - Digital controller that drives the fluid inputs of a convolving mixer mesh; it is the source end of the mesh datapath.
// - Per accepted command, meters reagent into each selected mesh input in ascending index order.
// - Each input gets a valve-settle phase, then a pumped inject phase.
// - After the last input, a flush phase purges the shared feed line, then completion is reported.
// PARAMETERS
// - N_INPUTS      2   number of mesh fluid inputs / inlet valves
// - CNT_W         16  width of dwell and phase counters
// - SETTLE_CYCLES 4   cycles a valve is open with the pump off before injecting (>=1)
// - FLUSH_CYCLES  8   cycles of flush valve open with the pump on (>=1)
// PORTS
// - clk         in   1         single clock, all state on posedge
// - rst         in   1         synchronous, active-high reset
// - cmd_valid   in   1         command request
// - cmd_ready   out  1         command accepted when cmd_valid && cmd_ready
// - cmd_mask    in   N_INPUTS  inputs to inject; bit i = mesh input i
// - cmd_dwell   in   CNT_W     inject cycles per selected input
// - abort       in   1         terminate the current sequence
// - valve_open  out  N_INPUTS  inlet valve drives, at most one bit high
// - flush_open  out  1         feed-line flush valve
// - pump_on     out  1         shared feed pump
// - active_idx  out  clog2(N)  index of the input currently open; 0 when none open
// - busy        out  1         high in every state except IDLE
// - done        out  1         one-cycle completion pulse
// - aborted     out  1         qualifies done; high only with done after an abort
// BEHAVIOUR
// - Reset: all outputs 0 except cmd_ready. Enter IDLE on the next edge, including mid-sequence; no flush is performed.
// - cmd_ready = (state==IDLE). Handshake in IDLE latches cmd_mask and cmd_dwell; later changes to the inputs are ignored.
// - cmd_valid outside IDLE is ignored, with no queuing.
// - States: IDLE -> SETTLE -> INJECT -> (SETTLE of next input | FLUSH) -> DONE -> IDLE.
// - Effective input set = latched mask bits, but only if dwell != 0. dwell == 0 or mask == 0 selects no inputs.
// - Accept edge: if an input is selected, go to SETTLE(lowest i); else go to FLUSH. An empty command still flushes.
// - SETTLE(i): valve_open = 1<<i, pump off, for SETTLE_CYCLES cycles, then INJECT(i).
// - INJECT(i): valve_open = 1<<i, pump_on = 1, for dwell cycles.
//   - Then go directly to SETTLE(next selected i), with no gap cycle, or to FLUSH.
// - FLUSH: valve_open = 0, flush_open = 1, pump_on = 1, for FLUSH_CYCLES cycles, then DONE.
// - DONE: done = 1 for one cycle, busy = 1, then IDLE.
// - Latency from the accept edge to done = sum over selected inputs of (SETTLE_CYCLES+dwell) + FLUSH_CYCLES + 1.
// - Invariants:
//   - flush_open and any valve_open bit are never high together.
//   - pump_on is never high without an open valve.
//   - All outputs are registered.
// - Abort:
//   - In SETTLE or INJECT: the next edge closes all valves and enters FLUSH with the full FLUSH_CYCLES.
//   - In FLUSH or DONE: ignored, the sequence completes normally.
//   - In IDLE: ignored.
//   - If abort was taken, aborted = 1 with the done pulse.
//   - abort and cmd_valid together in IDLE: the command is accepted.
// - Counters: the dwell count is compared without wrap; cmd_dwell = 2^CNT_W-1 is legal.
// TESTING
// - Setup: cycle 0 = accept edge; defaults SETTLE_CYCLES=4, FLUSH_CYCLES=8, N_INPUTS=2.
// - mask=11, dwell=3:
//   - valve_open=01 cycles 1-7, pump cycles 5-7.
//   - valve_open=10 cycles 8-14, pump cycles 12-14.
//   - flush cycles 15-22; done cycle 23, aborted=0.
// - mask=00, dwell=5: flush cycles 1-8, no valve ever open; done cycle 9; cmd_ready high again cycle 10.
// - mask=01, dwell=0: identical to the empty command (flush cycles 1-8, done cycle 9).
// - mask=11, dwell=3, abort at cycle 6:
//   - valves close at cycle 7; flush cycles 7-14.
//   - done=1 and aborted=1 at cycle 15; input 1 is never opened.
// - mask=10, dwell=2, rst at cycle 3:
//   - all outputs 0 at cycle 4, busy=0, cmd_ready=1.
//   - a new command at cycle 5 runs from SETTLE correctly.
// - cmd_valid held high with a new mask during the first sequence: no second accept until IDLE.
//   - The in-flight mask is unaffected; the second command starts immediately after done.

Source files
------------

// File: rtl/mesh_inject_sequencer.sv
// Source-end sequencer for the convolving mixer mesh: meters reagent into each
// selected inlet (settle, then pumped inject), flushes the feed line, reports done.

module mesh_inject_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_nxt,
  input  logic [IDX_W-1:0] idx_nxt,
  output logic             valve
);
  always_ff @(posedge clk) begin
    if (rst) valve <= 1'b0;
    else     valve <= open_nxt && (idx_nxt == IDX_W'(LANE));
  end
endmodule

module mesh_inject_sequencer #(
  parameter int N_INPUTS      = 2,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int FLUSH_CYCLES  = 8,
  localparam int IDX_W        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [N_INPUTS-1:0] cmd_mask,
  input  logic [CNT_W-1:0]    cmd_dwell,
  input  logic                abort,
  output logic [N_INPUTS-1:0] valve_open,
  output logic                flush_open,
  output logic                pump_on,
  output logic [IDX_W-1:0]    active_idx,
  output logic                busy,
  output logic                done,
  output logic                aborted
);
  typedef enum logic [2:0] {IDLE, SETTLE, INJECT, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);

  state_t              state, nxt_state;
  logic [IDX_W-1:0]    idx, nxt_idx;
  logic [CNT_W-1:0]    cnt, nxt_cnt;
  logic [CNT_W-1:0]    dwell_q, nxt_dwell;
  logic [N_INPUTS-1:0] mask_q, nxt_mask;
  logic                abort_q, nxt_abort;
  logic [N_INPUTS-1:0] cmd_sel, above;
  logic                first_vld, next_vld, nxt_open;
  logic [IDX_W-1:0]    first_idx, next_idx;

  function automatic logic [IDX_W:0] lowest(input logic [N_INPUTS-1:0] m);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--)
      if (m[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  // A zero dwell drops every input so the command degenerates to a bare flush.
  assign cmd_sel = (cmd_dwell != '0) ? cmd_mask : '0;

  always_comb begin
    above = '0;
    for (int i = 0; i < N_INPUTS; i++)
      above[i] = mask_q[i] && (i > int'(idx));
  end

  assign {first_vld, first_idx} = lowest(cmd_sel);
  assign {next_vld, next_idx}   = lowest(above);

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt + CNT_W'(1);
    nxt_mask  = mask_q;
    nxt_dwell = dwell_q;
    nxt_abort = abort_q;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (cmd_valid) begin
          nxt_mask  = cmd_sel;
          nxt_dwell = cmd_dwell;
          nxt_abort = 1'b0;
          if (first_vld) begin
            nxt_state = SETTLE;
            nxt_idx   = first_idx;
          end else begin
            nxt_state = FLUSH;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          nxt_state = FLUSH;
          nxt_cnt   = '0;
          nxt_abort = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          nxt_state = INJECT;
          nxt_cnt   = '0;
        end
      end
      INJECT: begin
        if (abort) begin
          nxt_state = FLUSH;
          nxt_cnt   = '0;
          nxt_abort = 1'b1;
        end else if (cnt == dwell_q - CNT_W'(1)) begin
          // dwell_q is nonzero here, so the subtract never wraps
          nxt_cnt = '0;
          if (next_vld) begin
            nxt_state = SETTLE;
            nxt_idx   = next_idx;
          end else begin
            nxt_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign nxt_open = (nxt_state == SETTLE) || (nxt_state == INJECT);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      mask_q     <= '0;
      dwell_q    <= '0;
      abort_q    <= 1'b0;
      flush_open <= 1'b0;
      pump_on    <= 1'b0;
      active_idx <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cmd_ready  <= 1'b1;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      mask_q     <= nxt_mask;
      dwell_q    <= nxt_dwell;
      abort_q    <= nxt_abort;
      flush_open <= (nxt_state == FLUSH);
      pump_on    <= (nxt_state == INJECT) || (nxt_state == FLUSH);
      active_idx <= nxt_open ? nxt_idx : '0;
      busy       <= (nxt_state != IDLE);
      done       <= (nxt_state == DONE);
      aborted    <= (nxt_state == DONE) && nxt_abort;
      cmd_ready  <= (nxt_state == IDLE);
    end
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
    mesh_inject_lane #(.LANE(g), .IDX_W(IDX_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .open_nxt (nxt_open),
      .idx_nxt  (nxt_idx),
      .valve    (valve_open[g])
    );
  end

endmodule
